alu_op_initiator: RTL and testbench

- Command-side initiator for the 8-bit combinational ALU (op 00 add, 01 subtract, 10 shift-left-by-4, 11 xor; overflow = add carry-out or subtract sign).
- Accepts operation commands over a valid/ready handshake and drives registered operands and opcode to the ALU.
- Captures the ALU result and overflow, then returns them through a small response FIFO.
- Supports chaining: the previous result replaces operand a, so multi-step arithmetic needs no host round-trip.

---
 rtl/alu_op_initiator.sv | 133 +++++++++++++
 tb/tb_alu_op_initiator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_initiator.sv
// Command initiator for the 8-bit combinational ALU.
// Registers operands, captures the result and queues it in a response FIFO.
module alu_op_initiator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           cmd_a,
  input  logic [WIDTH-1:0]           cmd_b,
  input  logic [1:0]                 cmd_op,
  input  logic                       cmd_chain,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [1:0]                 alu_op,
  input  logic [WIDTH-1:0]           alu_c,
  input  logic                       alu_overflow,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_overflow,
  output logic [$clog2(DEPTH):0]     rsp_count,
  output logic                       sticky_overflow,
  input  logic                       ovf_clear,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPTURE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   mem [DEPTH];
  logic [WIDTH:0]   head;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rnext;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   pdata;
  logic             accept;
  logic             push;
  logic             pop;

  assign cmd_ready = rst_n && (state == IDLE)
                   && (count < CW'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state == CAPTURE);
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (state != IDLE);
  assign rnext     = rptr + 1'b1;
  assign pdata     = {alu_overflow, alu_c};
  assign rsp_count = count;
  assign {rsp_overflow, rsp_data} = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= 2'b00;
      acc    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_a  <= cmd_chain ? acc : cmd_a;
            alu_b  <= cmd_b;
            alu_op <= cmd_op;
            state  <= DRIVE;
          end
        end
        DRIVE: state <= CAPTURE;
        CAPTURE: begin
          acc   <= alu_c;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_overflow <= 1'b0;
    end else if (push && alu_overflow) begin
      sticky_overflow <= 1'b1;
    end else if (ovf_clear) begin
      sticky_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= pdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rnext;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is registered so it holds the last value once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else if (pop && count > CW'(1)) begin
      head <= mem[rnext];
    end else if (push && (count == '0
                 || (pop && count == CW'(1)))) begin
      head <= pdata;
    end
  end

endmodule

// File: tb/tb_alu_op_initiator.sv
// Scoreboard bench for alu_op_initiator.
// Random and directed commands against an arithmetic reference model.
module tb_alu_op_initiator;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       cmd_valid = 0;
  logic       cmd_ready;
  logic [7:0] cmd_a = 0;
  logic [7:0] cmd_b = 0;
  logic [1:0] cmd_op = 0;
  logic       cmd_chain = 0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_c;
  logic       alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready = 1;
  logic [7:0] rsp_data;
  logic       rsp_overflow;
  logic [2:0] rsp_count;
  logic       sticky_overflow;
  logic       ovf_clear = 0;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] exp_q[$];
  logic [7:0] acc_m = 0;
  logic       sticky_m = 0;
  logic       rnd = 0;

  always #5 clk = ~clk;

  alu_op_initiator #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
    .rsp_count(rsp_count),
    .sticky_overflow(sticky_overflow),
    .ovf_clear(ovf_clear), .busy(busy)
  );

  // External combinational ALU
  always_comb begin
    alu_c = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      2'b00: {alu_overflow, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin
        alu_c = alu_a - alu_b;
        alu_overflow = alu_c[7];
      end
      2'b10: alu_c = {alu_a[3:0], 4'h0};
      default: alu_c = alu_a ^ alu_b;
    endcase
  end

  function automatic logic [8:0] ref_alu(int a, int b, int op);
    int r;
    int o;
    o = 0;
    case (op)
      0: begin r = a + b; o = (r > 255); r = r % 256; end
      1: begin r = (a - b + 256) % 256; o = (r >= 128); end
      2: r = (a * 16) % 256;
      default: r = a ^ b;
    endcase
    return {o[0], r[7:0]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got %0h expected none",
                 {rsp_overflow, rsp_data});
      end else begin
        chk("rsp", {23'd0, rsp_overflow, rsp_data}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    if (rnd) #1 rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input logic ch);
    int n;
    logic [7:0] ea;
    logic [8:0] r;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch;
    cmd_valid = 1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 0;
    ea = ch ? acc_m : a;
    r = ref_alu(ea, b, op);
    acc_m = r[7:0];
    sticky_m = sticky_m | r[8];
    exp_q.push_back(r);
  endtask

  task automatic wait_done();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1;
    while ((exp_q.size() != 0 || rsp_count != 0) && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain", {29'd0, rsp_count}, 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_count", {29'd0, rsp_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_sticky", {31'd0, sticky_overflow}, 32'd0);
    chk("rst_data", {23'd0, rsp_overflow, rsp_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // Add with carry, check operands and 2-cycle ready gap
    rsp_ready = 0;
    send(8'hF0, 8'h20, 2'b00, 0);
    chk("alu_a", {24'd0, alu_a}, 32'hF0);
    chk("alu_b", {24'd0, alu_b}, 32'h20);
    chk("gap0", {31'd0, cmd_ready}, 32'd0);
    chk("busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("gap1", {31'd0, cmd_ready}, 32'd0);
    chk("no_early", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("gap2", {31'd0, cmd_ready}, 32'd1);
    chk("count1", {29'd0, rsp_count}, 32'd1);
    chk("sticky1", {31'd0, sticky_overflow}, 32'd1);
    rsp_ready = 1;

    send(8'h05, 8'h09, 2'b01, 0);
    wait_done();
    send(8'h09, 8'h05, 2'b01, 0);
    wait_done();

    // Chaining
    send(8'h03, 8'h05, 2'b11, 0);
    wait_done();
    send(8'hAA, 8'h00, 2'b10, 1);
    chk("chain_a", {24'd0, alu_a}, 32'h06);
    wait_done();
    send(8'h55, 8'h60, 2'b11, 1);
    chk("chain_a2", {24'd0, alu_a}, 32'h60);
    wait_done();
    drain();

    // Backpressure
    rsp_ready = 0;
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom), 8'($urandom), 2'($urandom), 0);
      wait_done();
    end
    chk("full_count", {29'd0, rsp_count}, 32'd4);
    cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = 2'b00; cmd_chain = 0;
    cmd_valid = 1;
    repeat (3) @(negedge clk);
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("pop_count", {29'd0, rsp_count}, 32'd3);
    send(8'h11, 8'h22, 2'b00, 0);
    @(posedge clk); #1;
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("pushpop_count", {29'd0, rsp_count}, 32'd3);
    drain();

    // Reset during DRIVE
    send(8'h80, 8'h80, 2'b00, 0);
    rst_n = 0;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ar_alu_a", {24'd0, alu_a}, 32'd0);
    chk("ar_sticky", {31'd0, sticky_overflow}, 32'd0);
    exp_q.delete();
    acc_m = 0;
    sticky_m = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(posedge clk);
    #1 chk("no_stale", {31'd0, rsp_valid}, 32'd0);
    send(8'h12, 8'h34, 2'b11, 1);
    chk("post_rst_acc", {24'd0, alu_a}, 32'h00);
    wait_done();
    drain();

    // Sticky clear, then clear colliding with an overflowing capture
    send(8'hFF, 8'h01, 2'b00, 0);
    wait_done();
    chk("sticky_set", {31'd0, sticky_overflow}, 32'd1);
    ovf_clear = 1;
    @(posedge clk); #1;
    ovf_clear = 0;
    chk("sticky_clr", {31'd0, sticky_overflow}, 32'd0);
    send(8'hF0, 8'h20, 2'b00, 0);
    @(posedge clk); #1;
    ovf_clear = 1;
    @(posedge clk); #1;
    ovf_clear = 0;
    chk("sticky_win", {31'd0, sticky_overflow}, 32'd1);
    drain();

    // Random traffic with random backpressure
    ovf_clear = 1;
    @(posedge clk); #1;
    ovf_clear = 0;
    sticky_m = 0;
    rnd = 1;
    for (int i = 0; i < 60; i++) begin
      send(8'($urandom), 8'($urandom), 2'($urandom),
           1'($urandom_range(0, 1)));
      wait_done();
      chk("rnd_sticky", {31'd0, sticky_overflow}, {31'd0, sticky_m});
    end
    rnd = 0;
    @(posedge clk); #2;
    drain();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
